pixel_out_streamer: RTL and testbench
=====================================

PIXEL_OUT_STREAMER -- requirements
Module: pixel_out_streamer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: pixel FIFO entries, power of two, at least 2.
REQ-002 Parameter IMG_W, default 64: pixels per line.
REQ-003 Parameter IMG_H, default 64: lines per frame.
REQ-004 Parameter STROBE_CYCLES, default 2: cycles pixel_write is held high per pixel, at least 1.
REQ-005 The block SHALL use one clock, wb_clk_i; reset is synchronous and active-low, resetb, sampled on the rising edge of wb_clk_i.
REQ-006 Ports SHALL be:
 - wb_clk_i  in  1  clock
 - resetb  in  1  synchronous active-low reset
 - enable  in  1  allows output of pixels
 - s_valid  in  1  upstream rasterizer pixel valid
 - s_ready  out  1  FIFO can accept a pixel
 - s_color  in  8  grey level of the pixel
 - io_out  out  9  [7:0] color, [8] pixel_write, driven to mprj_io[8:0]
 - io_oeb  out  9  output enables, active-low
 - frame_done  out  1  one-cycle pulse after the last pixel of a frame
 - busy  out  1  FIFO not empty or FSM not IDLE
 - pix_count  out  12  pixels emitted in the current frame

Function
REQ-007 An upstream transfer SHALL occur on any clock edge where s_valid and s_ready are both high; s_color is then pushed into the FIFO.
REQ-008 s_ready SHALL equal NOT full. s_ready SHALL NOT depend combinationally on s_valid.
REQ-009 A push and a pop in the same cycle SHALL both take effect, and the occupancy SHALL stay the same.
REQ-010 The FSM SHALL have four states: IDLE, SETUP, STROBE and HOLD.
REQ-011 IDLE -> SETUP when enable=1 and the FIFO is not empty. On that transition the head of the FIFO is popped into color_reg.
REQ-012 SETUP: io_out[7:0]=color_reg, pixel_write=0, duration 1 cycle, then -> STROBE.
REQ-013 STROBE: pixel_write=1 and color is held, for exactly STROBE_CYCLES cycles, then -> HOLD.
REQ-014 HOLD: pixel_write=0 and color is held for 1 cycle.
 - Pixel counters advance in this state.
 - Next state is SETUP, with a pop, if enable=1 and the FIFO is not empty; otherwise IDLE.
REQ-015 In back-to-back operation each pixel SHALL take exactly STROBE_CYCLES+2 cycles.
REQ-016 Latency SHALL be as follows:
 - With the FIFO empty and enable=1, a pixel accepted at edge N reaches IDLE->SETUP at edge N+1.
 - pixel_write rises at edge N+2.
REQ-017 Deasserting enable SHALL NOT abort an in-flight pixel. The block completes HOLD, then goes to IDLE.
REQ-018 Counters x (0..IMG_W-1) and y (0..IMG_H-1) SHALL advance in HOLD.
 - x wraps to 0 and y increments.
 - At x=IMG_W-1 and y=IMG_H-1 both wrap to 0, and frame_done pulses high for the single cycle after HOLD.
REQ-019 pix_count SHALL equal y*IMG_W+x.
REQ-020 Color SHALL hold its last value while in IDLE. pixel_write SHALL be 0 in every state except STROBE.
REQ-021 io_oeb SHALL be 9'h000 whenever resetb=1.
REQ-022 Pushes when full SHALL be impossible, because s_ready=0. Pops when empty SHALL never occur.

Reset
REQ-023 While resetb=0, at each rising edge the block SHALL set:
 - state = IDLE
 - FIFO pointers and count = 0
 - x = 0, y = 0
 - color_reg = 8'h00
 - io_out = 9'h000
 - io_oeb = 9'h1FF
 - s_ready = 0
 - frame_done = 0
 - busy = 0
 - pix_count = 0
REQ-024 Reset asserted mid-pixel SHALL drive pixel_write low at the next edge and discard all buffered pixels.
REQ-025 s_ready SHALL go to 1 on the first edge after resetb=1.

Structure
REQ-026 Package gonso_pkg SHALL hold:
 - the FSM state enum (IDLE, SETUP, STROBE, HOLD)
 - IMG_W and IMG_H defaults
 - PIX_W=8
 - the io_out bit positions COLOR_LSB=0 and PIXEL_WRITE_BIT=8
REQ-027 The FIFO SHALL be a separate sub-module, pixel_fifo, parameterised by depth and width, exposing push, pop, din, dout, full, empty and count.
REQ-028 The strobe-length counter SHALL be sized to clog2(STROBE_CYCLES+1).

Verification
REQ-029 Single pixel: reset, enable=1, push 8'hA5 at edge 10.
 - Required response: SETUP at edge 11, pixel_write high on edges 12-13, HOLD at 14, IDLE at 15.
 - pix_count becomes 1.
REQ-030 Full frame: 4096 pixels with values (x^y)&8'hFF and upstream always valid.
 - Every pixel takes 4 cycles.
 - frame_done pulses exactly once, after the 4096th pixel.
 - pix_count returns to 0.
 - The captured 64x64 image matches the expected image.
REQ-031 Backpressure: enable=0, push 5 pixels.
 - s_ready drops after 4 pushes; the 5th is held.
 - After enable=1 all 5 pixels emerge in order with no loss or duplicate.
REQ-032 Enable drop: deassert enable during STROBE of pixel 3.
 - Pixel 3 completes its full strobe.
 - The FSM then idles, and pixel 4 waits until enable=1.
REQ-033 Reset mid-operation: assert resetb=0 during STROBE with 3 pixels queued.
 - Next edge: pixel_write=0 and io_oeb=9'h1FF.
 - After release: busy=0, pix_count=0, and no stale pixel is emitted.
REQ-034 Simultaneous push and pop with the FIFO at 3 entries: occupancy stays 3 and output order is preserved.

Source files
------------

// File: rtl/pixel_out_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gonso_pkg
// Description : Shared definitions for the pixel output streamer: FSM state
//               encoding, default image geometry, pixel width and io_out
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package gonso_pkg;

    localparam int IMG_W_DEFAULT   = 64;
    localparam int IMG_H_DEFAULT   = 64;
    localparam int PIX_W           = 8;
    localparam int COLOR_LSB       = 0;
    localparam int PIXEL_WRITE_BIT = 8;
    localparam int IO_W            = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_out_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface   : pixel_out_streamer_if
// Description : Valid/ready pixel stream from the upstream rasterizer.
//               master = rasterizer (drives s_valid, s_color)
//               slave  = streamer   (drives s_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_out_streamer_if;
    import gonso_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_color;

    modport master (output s_valid, output s_color, input s_ready);
    modport slave  (input s_valid, input s_color, output s_ready);

endinterface
`default_nettype wire

// File: rtl/pixel_out_streamer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous first-word-fall-through FIFO. dout always shows
//               the head entry. Push when full and pop when empty are
//               ignored.
// Ports       : clk, resetb (sync, active-low), push, pop, din, dout,
//               full, empty, count (occupancy, 0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       resetb,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_out_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_out_streamer
// Description : Buffers pixels from a rasterizer and drives them onto the
//               GPIO pads as color + pixel_write strobe. Each pixel runs
//               SETUP (1) -> STROBE (STROBE_CYCLES) -> HOLD (1).
// Ports       : wb_clk_i, resetb (sync, active-low), enable,
//               pix_in (stream slave: s_valid, s_ready, s_color),
//               io_out[8:0] ({pixel_write, color}), io_oeb[8:0],
//               frame_done, busy, pix_count[11:0]
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_out_streamer
    import gonso_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int IMG_W         = IMG_W_DEFAULT,
    parameter int IMG_H         = IMG_H_DEFAULT,
    parameter int STROBE_CYCLES = 2
) (
    input  wire logic              wb_clk_i,
    input  wire logic              resetb,
    input  wire logic              enable,
    pixel_out_streamer_if.slave    pix_in,
    output logic [IO_W-1:0]        io_out,
    output logic [IO_W-1:0]        io_oeb,
    output logic                   frame_done,
    output logic                   busy,
    output logic [11:0]            pix_count
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [PIX_W-1:0] r_color;
    logic [SW-1:0]    r_strb_cnt;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [11:0]      r_pix_count;
    logic             r_frame_done;
    logic             r_rst_done;

    logic             w_push;
    logic             w_pop;
    logic             w_pixel_write;
    logic             w_busy;
    logic [PIX_W-1:0] w_fifo_dout;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_strb_last;

    // s_ready is held low through reset and rises on the first edge after it.
    assign pix_in.s_ready = r_rst_done & ~w_full;
    assign w_push         = pix_in.s_valid & pix_in.s_ready;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk    (wb_clk_i),
        .resetb (resetb),
        .push   (w_push),
        .pop    (w_pop),
        .din    (pix_in.s_color),
        .dout   (w_fifo_dout),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    assign w_x_last    = (r_x == XW'(IMG_W - 1));
    assign w_y_last    = (r_y == YW'(IMG_H - 1));
    assign w_strb_last = (r_strb_cnt == SW'(STROBE_CYCLES - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wb_clk_i) begin
        if (!resetb) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (enable && !w_empty) w_next_state = SETUP;
            SETUP:   w_next_state = STROBE;
            STROBE:  if (w_strb_last) w_next_state = HOLD;
            HOLD:    w_next_state = (enable && !w_empty) ? SETUP : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_pop         = 1'b0;
        w_pixel_write = 1'b0;
        w_busy        = (w_count != '0) || (r_state != IDLE);
        case (r_state)
            IDLE:    w_pop = enable & ~w_empty;
            STROBE:  w_pixel_write = 1'b1;
            HOLD:    w_pop = enable & ~w_empty;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge wb_clk_i) begin
        if (!resetb) begin
            r_color      <= '0;
            r_strb_cnt   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_pix_count  <= '0;
            r_frame_done <= 1'b0;
            r_rst_done   <= 1'b0;
        end else begin
            r_rst_done   <= 1'b1;
            r_frame_done <= 1'b0;
            if (w_pop) r_color <= w_fifo_dout;

            if (r_state == SETUP)       r_strb_cnt <= '0;
            else if (r_state == STROBE) r_strb_cnt <= r_strb_cnt + SW'(1);

            // Raster position advances once per pixel, during HOLD.
            if (r_state == HOLD) begin
                if (w_x_last) begin
                    r_x <= '0;
                    if (w_y_last) begin
                        r_y          <= '0;
                        r_pix_count  <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y         <= r_y + YW'(1);
                        r_pix_count <= r_pix_count + 12'd1;
                    end
                end else begin
                    r_x         <= r_x + XW'(1);
                    r_pix_count <= r_pix_count + 12'd1;
                end
            end
        end
    end

    assign io_out[COLOR_LSB +: PIX_W] = r_color;
    assign io_out[PIXEL_WRITE_BIT]    = w_pixel_write;
    assign io_oeb                     = resetb ? {IO_W{1'b0}} : {IO_W{1'b1}};
    assign frame_done                 = r_frame_done;
    assign busy                       = w_busy;
    assign pix_count                  = r_pix_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_out_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_out_streamer
// Description : Directed self-checking bench for pixel_out_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_out_streamer;
    import gonso_pkg::*;

    logic        clk;
    logic        resetb;
    logic        enable;
    logic [8:0]  io_out;
    logic [8:0]  io_oeb;
    logic        frame_done;
    logic        busy;
    logic [11:0] pix_count;

    pixel_out_streamer_if bus ();

    pixel_out_streamer #(
        .FIFO_DEPTH    (4),
        .IMG_W         (64),
        .IMG_H         (64),
        .STROBE_CYCLES (2)
    ) dut (
        .wb_clk_i   (clk),
        .resetb     (resetb),
        .enable     (enable),
        .pix_in     (bus),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .frame_done (frame_done),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc_n    = 0;
    int         fd_cnt   = 0;
    int         fd_cyc   = 0;
    logic       prev_pw  = 1'b0;
    logic [7:0] cap [$];
    int         rise_t [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Capture one color per pixel_write rising edge, plus frame_done pulses.
    always @(negedge clk) begin
        if (io_out[8] && !prev_pw) begin
            cap.push_back(io_out[7:0]);
            rise_t.push_back(cyc_n);
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc_n;
        end
        prev_pw <= io_out[8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_pixel(input logic [7:0] c);
        logic ok;
        ok = 1'b0;
        bus.s_color = c;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.s_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        bus.s_valid = 1'b0;
        if (!ok) check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_cap(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (cap.size() >= n) break;
            @(negedge clk);
        end
        check("cap_count", 32'(cap.size()), 32'(n));
    endtask

    task automatic wait_strobe(input logic [7:0] c, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (io_out[8] && io_out[7:0] == c) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("strobe_seen", 32'(found), 32'd1);
    endtask

    initial begin
        int bad;
        int fd_base;
        resetb      = 1'b0;
        enable      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_color = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_io_out",     32'(io_out),     32'h000);
        check("rst_io_oeb",     32'(io_oeb),     32'h1FF);
        check("rst_s_ready",    32'(bus.s_ready), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_pix_count",  32'(pix_count),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        resetb = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 32'(bus.s_ready), 32'd1);
        check("rel_io_oeb",  32'(io_oeb),     32'h000);

        // ---------------- single pixel ----------------
        bus.s_color = 8'hA5;
        bus.s_valid = 1'b1;
        @(negedge clk);                                   // edge N: push
        bus.s_valid = 1'b0;
        check("sp_n_state", 32'(dut.r_state), 32'(IDLE));
        check("sp_n_busy",  32'(busy),        32'd1);
        @(negedge clk);                                   // N+1
        check("sp_setup_state", 32'(dut.r_state), 32'(SETUP));
        check("sp_setup_io",    32'(io_out),      32'h0A5);
        @(negedge clk);                                   // N+2
        check("sp_strobe1_io", 32'(io_out), 32'h1A5);
        @(negedge clk);                                   // N+3
        check("sp_strobe2_io", 32'(io_out), 32'h1A5);
        @(negedge clk);                                   // N+4
        check("sp_hold_state", 32'(dut.r_state), 32'(HOLD));
        check("sp_hold_io",    32'(io_out),      32'h0A5);
        @(negedge clk);                                   // N+5
        check("sp_idle_state", 32'(dut.r_state), 32'(IDLE));
        check("sp_idle_io",    32'(io_out),      32'h0A5);
        check("sp_pix_count",  32'(pix_count),   32'd1);
        check("sp_idle_busy",  32'(busy),        32'd0);
        check("sp_cap",        32'(cap[0]),      32'hA5);

        // ---------------- backpressure ----------------
        cap.delete();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_ready_before_push", 32'(bus.s_ready), 32'd1);
            push_pixel(8'(8'h10 + i));
        end
        bus.s_color = 8'h14;
        bus.s_valid = 1'b1;
        check("bp_ready_full", 32'(bus.s_ready),   32'd0);
        check("bp_count_full", 32'(dut.w_count),   32'd4);
        repeat (2) @(negedge clk);
        check("bp_still_held", 32'(bus.s_ready), 32'd0);
        check("bp_no_output",  32'(cap.size()),  32'd0);
        enable = 1'b1;
        push_pixel(8'h14);
        wait_cap(5, 100);
        for (int i = 0; i < 5; i++) check("bp_order", 32'(cap[i]), 32'(8'h10 + i));
        repeat (30) @(negedge clk);
        check("bp_no_dup", 32'(cap.size()), 32'd5);

        // ---------------- enable drop during pixel 3 strobe ----------------
        cap.delete();
        for (int i = 0; i < 4; i++) push_pixel(8'(8'h20 + i));
        wait_strobe(8'h22, 100);
        enable = 1'b0;
        @(negedge clk);
        check("ed_strobe2", 32'(io_out), 32'h122);
        @(negedge clk);
        check("ed_hold_state", 32'(dut.r_state), 32'(HOLD));
        check("ed_hold_io",    32'(io_out),      32'h022);
        @(negedge clk);
        check("ed_idle_state", 32'(dut.r_state), 32'(IDLE));
        repeat (5) @(negedge clk);
        check("ed_wait_state", 32'(dut.r_state), 32'(IDLE));
        check("ed_wait_busy",  32'(busy),        32'd1);
        check("ed_wait_io",    32'(io_out),      32'h022);
        check("ed_wait_cap",   32'(cap.size()),  32'd3);
        enable = 1'b1;
        wait_cap(4, 100);
        check("ed_pixel4", 32'(cap[3]), 32'h23);

        // ---------------- simultaneous push and pop at 3 entries ----------------
        repeat (10) @(negedge clk);
        cap.delete();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_pixel(8'(8'h30 + i));
        check("pp_count_before", 32'(dut.w_count), 32'd3);
        enable      = 1'b1;
        bus.s_color = 8'h33;
        bus.s_valid = 1'b1;
        @(negedge clk);                                   // push and pop together
        bus.s_valid = 1'b0;
        check("pp_count_after", 32'(dut.w_count),  32'd3);
        check("pp_state",       32'(dut.r_state),  32'(SETUP));
        wait_cap(4, 100);
        for (int i = 0; i < 4; i++) check("pp_order", 32'(cap[i]), 32'(8'h30 + i));
        repeat (10) @(negedge clk);
        check("pp_pix_count", 32'(pix_count), 32'd14);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 4; i++) push_pixel(8'(8'h40 + i));
        wait_strobe(8'h40, 100);
        check("mr_queued", 32'(dut.w_count), 32'd3);
        resetb = 1'b0;
        @(negedge clk);
        check("mr_pw_low",   32'(io_out[8]),     32'd0);
        check("mr_io_out",   32'(io_out),        32'h000);
        check("mr_io_oeb",   32'(io_oeb),        32'h1FF);
        check("mr_s_ready",  32'(bus.s_ready),   32'd0);
        check("mr_count",    32'(dut.w_count),   32'd0);
        resetb = 1'b1;
        cap.delete();
        @(negedge clk);
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_pix_count", 32'(pix_count), 32'd0);
        repeat (20) @(negedge clk);
        check("mr_no_stale", 32'(cap.size()), 32'd0);

        // ---------------- full frame ----------------
        cap.delete();
        rise_t.delete();
        fd_base = fd_cnt;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                push_pixel(8'((x ^ y) & 255));
        wait_cap(4096, 1000);
        repeat (6) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4096 && i < cap.size(); i++)
            if (cap[i] !== 8'(((i % 64) ^ (i / 64)) & 255)) bad++;
        check("ff_image_errors", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++)
            if (rise_t[i] - rise_t[i-1] != 4) bad++;
        check("ff_spacing_errors", 32'(bad),               32'd0);
        check("ff_frame_done_cnt", 32'(fd_cnt - fd_base),  32'd1);
        if (rise_t.size() > 0)
            check("ff_frame_done_time", 32'(fd_cyc - rise_t[rise_t.size()-1]), 32'd3);
        check("ff_pix_count", 32'(pix_count), 32'd0);
        check("ff_busy",      32'(busy),      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
